// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared helpers for the dual-clock FIFO pointer controllers.
//   bin2gray / gray2bin : pointer code conversions. They work on a 32-bit
//                         container; narrower pointers are zero-extended in and
//                         truncated out, which is exact for both directions.
//   af_default          : reset value of the almost_full threshold (DEPTH - 2).
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

    localparam int PTR_FN_W = 32;

    function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] g);
        logic [PTR_FN_W-1:0] b;
        b[PTR_FN_W-1] = g[PTR_FN_W-1];
        for (int i = PTR_FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int af_default(input int addr_w);
        return (1 << addr_w) - 2;
    endfunction

endpackage

// File: rtl/write_ptr_ctrl_if.sv
// -----------------------------------------------------------------------------
// write_ptr_ctrl_if
// Bundles the write-side FIFO pointer signals.
//   master : the write client (drives w_en, rptr_sync, af_load, af_thresh_in,
//            ovf_clr; observes the rest)
//   slave  : write_ptr_ctrl
// Signals:
//   w_en         write request
//   rptr_sync    Gray read pointer, already synchronised into wclk
//   af_load      load af_thresh_in into the almost_full threshold
//   af_thresh_in new almost_full threshold
//   ovf_clr      clear sticky overflow (and drop counter when enabled)
//   waddr        memory write address
//   wptr         registered Gray write pointer for the read-side synchroniser
//   w_ack        combinational write accept / memory write enable
//   full, almost_full, wlevel, overflow, drop_cnt  status outputs
// -----------------------------------------------------------------------------
interface write_ptr_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              w_en;
    logic [ADDR_W:0]   rptr_sync;
    logic              af_load;
    logic [ADDR_W:0]   af_thresh_in;
    logic              ovf_clr;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W:0]   wptr;
    logic              w_ack;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wlevel;
    logic              overflow;
    logic [15:0]       drop_cnt;

    modport master (
        output w_en, rptr_sync, af_load, af_thresh_in, ovf_clr,
        input  waddr, wptr, w_ack, full, almost_full, wlevel, overflow, drop_cnt
    );

    modport slave (
        input  w_en, rptr_sync, af_load, af_thresh_in, ovf_clr,
        output waddr, wptr, w_ack, full, almost_full, wlevel, overflow, drop_cnt
    );
endinterface

// File: rtl/ptr_gray2bin.sv
// -----------------------------------------------------------------------------
// ptr_gray2bin
// Purely combinational Gray-to-binary converter, width W.
//   gray : Gray-coded input
//   bin  : binary output; bin[i] is the XOR of all gray bits at or above i
// -----------------------------------------------------------------------------
module ptr_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end
endmodule

// File: rtl/write_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// write_ptr_ctrl
// Write-side pointer controller for the dual-clock FIFO (wclk domain only).
// Keeps the binary write counter and its registered Gray copy, and derives
// full / almost_full / fill level / sticky overflow from the synchronised
// Gray read pointer.
// Ports:
//   wclk   write clock (rising edge)
//   w_rst  synchronous active-high reset
//   bus    write_ptr_ctrl_if.slave (see interface header for signal list)
// Parameters:
//   ADDR_W      memory address width, DEPTH = 2**ADDR_W, ADDR_W >= 2
//   AF_DEFAULT  almost_full threshold loaded at reset
// Build option:
//   WPTR_DROP_CNT_EN  when defined, drop_cnt is a 16-bit saturating count of
//                     writes attempted while full; otherwise drop_cnt is 0.
// -----------------------------------------------------------------------------
module write_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int AF_DEFAULT = af_default(ADDR_W)
) (
    input logic             wclk,
    input logic             w_rst,
    write_ptr_ctrl_if.slave bus
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] THR_RST = PW'(AF_DEFAULT);

    logic          vld_p0;
    logic [PW-1:0] wbin_p0;
    logic [PW-1:0] wptr_p0;
    logic [PW-1:0] rbin_p0;
    logic [PW-1:0] level_p0;
    logic [PW-1:0] rptr_flip_p0;
    logic          full_p0;
    logic          af_p0;
    logic          ovf_set_p0;

    logic [PW-1:0] wbin_p1;
    logic [PW-1:0] wptr_p1;
    logic [PW-1:0] level_p1;
    logic [PW-1:0] thr_p1;
    logic          full_p1;
    logic          af_p1;
    logic          ovf_p1;

    ptr_gray2bin #(.W(PW)) u_rptr_g2b (
        .gray (bus.rptr_sync),
        .bin  (rbin_p0)
    );

    // ---- stage p0: accept decision and next-state pointers ----
    // full_p1 is the registered flag, so a write arriving in the same cycle
    // that the read side frees a slot is still rejected.
    assign vld_p0   = bus.w_en & ~full_p1 & ~w_rst;
    assign wbin_p0  = wbin_p1 + PW'(vld_p0);
    assign wptr_p0  = PW'(bin2gray(PTR_FN_W'(wbin_p0)));

    // Full when the pointers differ by exactly DEPTH: in Gray code that is
    // the read pointer with its top two bits inverted.
    assign rptr_flip_p0 = {~bus.rptr_sync[ADDR_W:ADDR_W-1], bus.rptr_sync[ADDR_W-2:0]};
    assign full_p0      = (wptr_p0 == rptr_flip_p0);

    // Modular difference is always 0..DEPTH; pessimistic because rptr_sync lags.
    assign level_p0   = wbin_p0 - rbin_p0;
    assign af_p0      = (level_p0 >= thr_p1);
    assign ovf_set_p0 = bus.w_en & full_p1;

    // ---- stage p1: registered pointer and status ----
    always_ff @(posedge wclk) begin
        if (w_rst) begin
            wbin_p1  <= '0;
            wptr_p1  <= '0;
            level_p1 <= '0;
            thr_p1   <= THR_RST;
            full_p1  <= 1'b0;
            af_p1    <= 1'b0;
            ovf_p1   <= 1'b0;
        end else begin
            wbin_p1  <= wbin_p0;
            wptr_p1  <= wptr_p0;
            level_p1 <= level_p0;
            full_p1  <= full_p0;
            af_p1    <= af_p0;
            if (bus.af_load) begin
                thr_p1 <= bus.af_thresh_in;
            end
            // set has priority over clear
            if (ovf_set_p0) begin
                ovf_p1 <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_p1 <= 1'b0;
            end
        end
    end

`ifdef WPTR_DROP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] drop_p1;

    // clear has priority over increment
    always_ff @(posedge wclk) begin
        if (w_rst || bus.ovf_clr) begin
            drop_p1 <= '0;
        end else if (ovf_set_p0) begin
            drop_p1 <= sat_inc16(drop_p1);
        end
    end

    assign bus.drop_cnt = drop_p1;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.w_ack       = vld_p0;
    assign bus.waddr       = wbin_p1[ADDR_W-1:0];
    assign bus.wptr        = wptr_p1;
    assign bus.full        = full_p1;
    assign bus.almost_full = af_p1;
    assign bus.wlevel      = level_p1;
    assign bus.overflow    = ovf_p1;

endmodule
